mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the `byte_addressable` memory wrapper. Port 0 is instruction fetch and port 1 is data load/store. The block serialises their requests with round-robin fairness and drives the memory's `address`/`write`/`d0..d3` inputs. It also runs the wrapper's write handshake (`write` held until `done`, then released) and returns read data, completion and misalignment error to the winner.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: write-size codes, sequencer states
// and the latched request record.
package mem_pkg;

    localparam logic [1:0] WR_NONE = 2'd0;
    localparam logic [1:0] WR_BYTE = 2'd1;
    localparam logic [1:0] WR_HALF = 2'd2;
    localparam logic [1:0] WR_WORD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_WR_BUSY,
        ST_WR_RELEASE,
        ST_ERR
    } state_e;

    // data[3] is d0, the most significant byte of the word
    typedef struct packed {
        logic [31:0]     addr;
        logic [1:0]      write;
        logic [3:0][7:0] data;
        logic            port;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a registered record of which port won last.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       grant_valid_o,
    output logic       grant_port_o
);

    logic last_q, last_d;

    // On a tie the port that did not win last time goes first
    always_comb begin
        grant_valid_o = |req_i;
        grant_port_o  = 1'b0;
        if (req_i == 2'b11) begin
            grant_port_o = ~last_q;
        end else if (req_i[1]) begin
            grant_port_o = 1'b1;
        end
        last_d = last_q;
        if (update_i) begin
            last_d = grant_port_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ~RR_INIT;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto the byte_addressable wrapper
// and sequences its read timing and write/done handshake.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_i,
    input  logic [31:0] p0_address_i,
    input  logic [1:0]  p0_write_i,
    input  logic [7:0]  p0_d0_i,
    input  logic [7:0]  p0_d1_i,
    input  logic [7:0]  p0_d2_i,
    input  logic [7:0]  p0_d3_i,
    output logic        p0_ack_o,
    output logic        p0_err_o,
    output logic [7:0]  p0_q0_o,
    output logic [7:0]  p0_q1_o,
    output logic [7:0]  p0_q2_o,
    output logic [7:0]  p0_q3_o,
    input  logic        p1_req_i,
    input  logic [31:0] p1_address_i,
    input  logic [1:0]  p1_write_i,
    input  logic [7:0]  p1_d0_i,
    input  logic [7:0]  p1_d1_i,
    input  logic [7:0]  p1_d2_i,
    input  logic [7:0]  p1_d3_i,
    output logic        p1_ack_o,
    output logic        p1_err_o,
    output logic [7:0]  p1_q0_o,
    output logic [7:0]  p1_q1_o,
    output logic [7:0]  p1_q2_o,
    output logic [7:0]  p1_q3_o,
    output logic [31:0] mem_address_o,
    output logic [1:0]  mem_write_o,
    output logic [7:0]  mem_d0_o,
    output logic [7:0]  mem_d1_o,
    output logic [7:0]  mem_d2_o,
    output logic [7:0]  mem_d3_o,
    input  logic        mem_done_i,
    input  logic [7:0]  mem_q0_i,
    input  logic [7:0]  mem_q1_i,
    input  logic [7:0]  mem_q2_i,
    input  logic [7:0]  mem_q3_i
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    req_t            p0Req, p1Req;
    logic            p0_ack_q, p1_ack_q, p0_err_q, p1_err_q;
    logic [3:0][7:0] p0_rdata_q, p1_rdata_q;
    logic [3:0][7:0] memQ;
    logic            grantValid, grantPort, arbUpdate;
    logic            ackValid, errValid, capRead;

    assign p0Req = '{addr: p0_address_i, write: p0_write_i,
                     data: {p0_d0_i, p0_d1_i, p0_d2_i, p0_d3_i}, port: 1'b0};
    assign p1Req = '{addr: p1_address_i, write: p1_write_i,
                     data: {p1_d0_i, p1_d1_i, p1_d2_i, p1_d3_i}, port: 1'b1};
    assign memQ  = {mem_q0_i, mem_q1_i, mem_q2_i, mem_q3_i};

    // A port whose ack is showing this cycle is masked so a lingering req is not re-granted
    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req_i        ({p1_req_i & ~p1_ack_q, p0_req_i & ~p0_ack_q}),
        .update_i     (arbUpdate),
        .grant_valid_o(grantValid),
        .grant_port_o (grantPort)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        arbUpdate = 1'b0;
        ackValid  = 1'b0;
        errValid  = 1'b0;
        capRead   = 1'b0;
        unique case (state_q)
            // A done still high from a drained write blocks new grants
            ST_IDLE: begin
                if (grantValid && !mem_done_i) begin
                    arbUpdate = 1'b1;
                    req_d     = grantPort ? p1Req : p0Req;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (req_q.addr[1:0] != 2'b00) begin
                    state_d = ST_ERR;
                end else if (req_q.write == WR_NONE) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_WR_BUSY;
                end
            end
            ST_ERR: begin
                ackValid = 1'b1;
                errValid = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_RD_WAIT: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                ackValid = 1'b1;
                capRead  = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_WR_BUSY: begin
                if (mem_done_i) begin
                    state_d = ST_WR_RELEASE;
                end
            end
            ST_WR_RELEASE: begin
                if (!mem_done_i) begin
                    ackValid = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            p0_ack_q <= ackValid & ~req_q.port;
            p1_ack_q <= ackValid &  req_q.port;
            p0_err_q <= errValid & ~req_q.port;
            p1_err_q <= errValid &  req_q.port;
            if (capRead && !req_q.port) begin
                p0_rdata_q <= memQ;
            end
            if (capRead && req_q.port) begin
                p1_rdata_q <= memQ;
            end
        end
    end

    assign p0_ack_o = p0_ack_q;
    assign p1_ack_o = p1_ack_q;
    assign p0_err_o = p0_err_q;
    assign p1_err_o = p1_err_q;
    assign {p0_q0_o, p0_q1_o, p0_q2_o, p0_q3_o} = p0_rdata_q;
    assign {p1_q0_o, p1_q1_o, p1_q2_o, p1_q3_o} = p1_rdata_q;

    assign mem_address_o = (state_q != ST_IDLE) ? req_q.addr : 32'd0;
    assign {mem_d0_o, mem_d1_o, mem_d2_o, mem_d3_o} = (state_q != ST_IDLE) ? req_q.data : '0;
    assign mem_write_o   = (state_q == ST_WR_BUSY) ? req_q.write : WR_NONE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte_addressable wrapper model plus a word-level
// reference memory, driven by directed and random port traffic.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0Req, p1Req;
    logic [31:0] p0Addr, p1Addr, p0Data, p1Data;
    logic [1:0]  p0Wr, p1Wr;
    wire         p0Ack, p1Ack, p0Err, p1Err;
    wire  [31:0] p0Q, p1Q, memD;
    wire  [31:0] memAddr;
    wire  [1:0]  memWr;
    logic        memDone;
    logic [31:0] memQ;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_req_i(p0Req), .p0_address_i(p0Addr), .p0_write_i(p0Wr),
        .p0_d0_i(p0Data[31:24]), .p0_d1_i(p0Data[23:16]), .p0_d2_i(p0Data[15:8]), .p0_d3_i(p0Data[7:0]),
        .p0_ack_o(p0Ack), .p0_err_o(p0Err),
        .p0_q0_o(p0Q[31:24]), .p0_q1_o(p0Q[23:16]), .p0_q2_o(p0Q[15:8]), .p0_q3_o(p0Q[7:0]),
        .p1_req_i(p1Req), .p1_address_i(p1Addr), .p1_write_i(p1Wr),
        .p1_d0_i(p1Data[31:24]), .p1_d1_i(p1Data[23:16]), .p1_d2_i(p1Data[15:8]), .p1_d3_i(p1Data[7:0]),
        .p1_ack_o(p1Ack), .p1_err_o(p1Err),
        .p1_q0_o(p1Q[31:24]), .p1_q1_o(p1Q[23:16]), .p1_q2_o(p1Q[15:8]), .p1_q3_o(p1Q[7:0]),
        .mem_address_o(memAddr), .mem_write_o(memWr),
        .mem_d0_o(memD[31:24]), .mem_d1_o(memD[23:16]), .mem_d2_o(memD[15:8]), .mem_d3_o(memD[7:0]),
        .mem_done_i(memDone),
        .mem_q0_i(memQ[31:24]), .mem_q1_i(memQ[23:16]), .mem_q2_i(memQ[15:8]), .mem_q3_i(memQ[7:0])
    );

    // Wrapper model: registered read, write committed a few cycles after write is seen,
    // done held until write drops; an abandoned write still drains to done
    logic [7:0]  ram [0:1023];
    logic        wBusy = 1'b0;
    int          wCnt = 0;
    logic [31:0] wAddr, wData;
    logic [1:0]  wSize;
    initial memDone = 1'b0;

    always @(posedge clk) begin
        memQ <= {ram[{memAddr[9:2], 2'd0}], ram[{memAddr[9:2], 2'd1}],
                 ram[{memAddr[9:2], 2'd2}], ram[{memAddr[9:2], 2'd3}]};
        if (!wBusy && !memDone && memWr != WR_NONE) begin
            wBusy <= 1'b1;
            wCnt  <= 3;
            wAddr <= memAddr;
            wData <= memD;
            wSize <= memWr;
        end else if (wBusy) begin
            if (wCnt > 1) begin
                wCnt <= wCnt - 1;
            end else begin
                ram[{wAddr[9:2], 2'd0}] <= wData[31:24];
                if (wSize != WR_BYTE) ram[{wAddr[9:2], 2'd1}] <= wData[23:16];
                if (wSize == WR_WORD) begin
                    ram[{wAddr[9:2], 2'd2}] <= wData[15:8];
                    ram[{wAddr[9:2], 2'd3}] <= wData[7:0];
                end
                wBusy   <= 1'b0;
                memDone <= 1'b1;
            end
        end else if (memDone && memWr == WR_NONE) begin
            memDone <= 1'b0;
        end
    end

    // Observers for protocol-level properties
    int   ackLog[$];
    logic bothAck = 1'b0, wrSeen = 1'b0, doneRose = 1'b0, doneFell = 1'b0;
    logic dropSeen = 1'b0, prevDone = 1'b0, p0ReqPrev = 1'b0, p1ReqPrev = 1'b0;

    always @(negedge clk) begin
        if (p0Ack && p1Ack) bothAck = 1'b1;
        if (p0Ack) ackLog.push_back(0);
        if (p1Ack) ackLog.push_back(1);
        if (memWr != WR_NONE) wrSeen = 1'b1;
        if (memDone && !prevDone) doneRose = 1'b1;
        if (!memDone && prevDone) doneFell = 1'b1;
        prevDone = memDone;
    end

    // A requester may only drop req in its ack cycle (or under reset)
    always @(posedge clk) begin
        if (!reset && p0ReqPrev && !p0Req && !p0Ack) dropSeen = 1'b1;
        if (!reset && p1ReqPrev && !p1Req && !p1Ack) dropSeen = 1'b1;
        p0ReqPrev = p0Req;
        p1ReqPrev = p1Req;
    end

    // Reference memory, one 32-bit word per aligned address, d0 as MSB
    logic [31:0] refMem [0:255];

    function automatic logic [31:0] refApply(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [31:0] d);
        case (sz)
            WR_BYTE: return (old & 32'h00FF_FFFF) | (d & 32'hFF00_0000);
            WR_HALF: return (old & 32'h0000_FFFF) | (d & 32'hFFFF_0000);
            WR_WORD: return d;
            default: return old;
        endcase
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        ram[{a[9:2], 2'd0}] <= w[31:24];
        ram[{a[9:2], 2'd1}] <= w[23:16];
        ram[{a[9:2], 2'd2}] <= w[15:8];
        ram[{a[9:2], 2'd3}] <= w[7:0];
        refMem[a[9:2]] = w;
    endtask

    // Called just after a negedge; returns just after the negedge showing ack
    task automatic access(input int port, input logic [31:0] addr, input logic [1:0] wr,
                          input logic [31:0] data, output logic [31:0] rq, output logic rerr,
                          output int lat, output logic ok);
        if (port == 0) begin
            p0Req = 1'b1; p0Addr = addr; p0Wr = wr; p0Data = data;
        end else begin
            p1Req = 1'b1; p1Addr = addr; p1Wr = wr; p1Data = data;
        end
        lat = 0; ok = 1'b0; rq = '0; rerr = 1'b0;
        while (!ok && lat < 100) begin
            @(negedge clk);
            lat++;
            if (port == 0 && p0Ack) begin ok = 1'b1; rq = p0Q; rerr = p0Err; end
            if (port == 1 && p1Ack) begin ok = 1'b1; rq = p1Q; rerr = p1Err; end
        end
        if (port == 0) p0Req = 1'b0; else p1Req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        p0Req = 1'b0; p1Req = 1'b0;
        p0Addr = '0; p1Addr = '0; p0Wr = WR_NONE; p1Wr = WR_NONE; p0Data = '0; p1Data = '0;
        repeat (2) @(negedge clk);
        checks++; if ({p0Ack, p1Ack} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ack: got %b required 00", {p0Ack, p1Ack}); end
        checks++; if ({p0Err, p1Err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_err: got %b required 00", {p0Err, p1Err}); end
        checks++; if (p0Q !== 32'd0) begin failures++; $display("[TB] FAIL reset_p0q: got %h required 0", p0Q); end
        checks++; if (p1Q !== 32'd0) begin failures++; $display("[TB] FAIL reset_p1q: got %h required 0", p1Q); end
        checks++; if (memAddr !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_address: got %h required 0", memAddr); end
        checks++; if (memWr !== WR_NONE) begin failures++; $display("[TB] FAIL reset_mem_write: got %0d required 0", memWr); end
        checks++; if (memD !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_d: got %h required 0", memD); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic [31:0] rq; logic rerr, ok; int lat;
        preload(32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        wrSeen = 1'b0;
        access(0, 32'h100, WR_NONE, 32'd0, rq, rerr, lat, ok);
        checks++; if (!ok || lat != 4) begin failures++; $display("[TB] FAIL read_latency: got %0d (ok=%0d) required 4", lat, ok); end
        checks++; if (rq !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL read_data: got %h required deadbeef", rq); end
        checks++; if (rerr !== 1'b0) begin failures++; $display("[TB] FAIL read_err: got %b required 0", rerr); end
        checks++; if (wrSeen !== 1'b0) begin failures++; $display("[TB] FAIL read_mem_write: got %b required 0", wrSeen); end
    endtask

    task automatic test_write_read();
        logic [31:0] rq; logic rerr, ok; int lat;
        @(negedge clk);
        doneRose = 1'b0; doneFell = 1'b0;
        access(1, 32'h40, WR_WORD, 32'h1122_3344, rq, rerr, lat, ok);
        checks++; if (!ok || rerr !== 1'b0) begin failures++; $display("[TB] FAIL write_ack: got ok=%0d err=%b required ok=1 err=0", ok, rerr); end
        checks++; if ({doneRose, doneFell} !== 2'b11) begin failures++; $display("[TB] FAIL write_handshake: got rose/fell %b required 11", {doneRose, doneFell}); end
        refMem[8'h10] = refApply(refMem[8'h10], WR_WORD, 32'h1122_3344);
        @(negedge clk);
        access(1, 32'h40, WR_NONE, 32'd0, rq, rerr, lat, ok);
        checks++; if (!ok || rq !== refMem[8'h10]) begin failures++; $display("[TB] FAIL write_readback: got %h required %h", rq, refMem[8'h10]); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rq, d; logic rerr, ok; int lat;
        preload(32'h80, 32'hAABB_CCDD);
        d = {8'h55, 24'($urandom)};
        @(negedge clk);
        access(1, 32'h80, WR_BYTE, d, rq, rerr, lat, ok);
        checks++; if (!ok || rerr !== 1'b0) begin failures++; $display("[TB] FAIL byte_write_ack: got ok=%0d err=%b required ok=1 err=0", ok, rerr); end
        refMem[8'h20] = refApply(refMem[8'h20], WR_BYTE, d);
        @(negedge clk);
        access(0, 32'h80, WR_NONE, 32'd0, rq, rerr, lat, ok);
        checks++; if (rq !== 32'h55BB_CCDD) begin failures++; $display("[TB] FAIL byte_write_readback: got %h required 55bbccdd", rq); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rq; logic rerr, ok; int lat;
        @(negedge clk);
        wrSeen = 1'b0;
        access(1, 32'h102, WR_WORD, $urandom, rq, rerr, lat, ok);
        checks++; if (!ok || lat != 3) begin failures++; $display("[TB] FAIL misaligned_latency: got %0d (ok=%0d) required 3", lat, ok); end
        checks++; if (rerr !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_err: got %b required 1", rerr); end
        checks++; if (wrSeen !== 1'b0) begin failures++; $display("[TB] FAIL misaligned_mem_write: got %b required 0", wrSeen); end
        @(negedge clk);
        access(0, 32'h100, WR_NONE, 32'd0, rq, rerr, lat, ok);
        checks++; if (rq !== refMem[8'h40]) begin failures++; $display("[TB] FAIL misaligned_untouched: got %h required %h", rq, refMem[8'h40]); end
    endtask

    task automatic test_contention();
        logic [31:0] rdQ [3]; logic rdE [3]; int rdL [3]; logic rdOk [3];
        logic [31:0] wrQ [3]; logic wrE [3]; int wrL [3]; logic wrOk [3];
        logic [31:0] wrD [3];
        logic [31:0] rq; logic rerr, ok, orderOk; int lat;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            preload(32'h300 + 32'(4 * i), $urandom);
            wrD[i] = $urandom;
        end
        @(negedge clk);
        ackLog.delete();
        bothAck = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    access(0, 32'h300 + 32'(4 * i), WR_NONE, 32'd0, rdQ[i], rdE[i], rdL[i], rdOk[i]);
                    @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    access(1, 32'h380 + 32'(4 * j), WR_WORD, wrD[j], wrQ[j], wrE[j], wrL[j], wrOk[j]);
                    @(negedge clk);
                end
            end
        join
        orderOk = (ackLog.size() == 6);
        for (int i = 0; i < ackLog.size() && i < 6; i++) begin
            if (ackLog[i] != (i % 2)) orderOk = 1'b0;
        end
        checks++; if (!orderOk) begin failures++; $display("[TB] FAIL contention_order: got %0d acks %p required 0,1,0,1,0,1", ackLog.size(), ackLog); end
        checks++; if (bothAck !== 1'b0) begin failures++; $display("[TB] FAIL contention_both_ack: got %b required 0", bothAck); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (!rdOk[i] || rdQ[i] !== refMem[8'hC0 + 8'(i)]) begin failures++; $display("[TB] FAIL contention_read%0d: got %h required %h", i, rdQ[i], refMem[8'hC0 + 8'(i)]); end
            if (wrOk[i]) refMem[8'hE0 + 8'(i)] = refApply(refMem[8'hE0 + 8'(i)], WR_WORD, wrD[i]);
        end
        for (int i = 0; i < 3; i++) begin
            access(0, 32'h380 + 32'(4 * i), WR_NONE, 32'd0, rq, rerr, lat, ok);
            checks++; if (!ok || rq !== wrD[i]) begin failures++; $display("[TB] FAIL contention_write%0d: got %h required %h", i, rq, wrD[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] rq, addr, d; logic rerr, ok, misal; int lat, port; logic [1:0] wr; logic [7:0] w8;
        for (int k = 0; k < 24; k++) begin
            port  = int'($urandom_range(0, 1));
            wr    = 2'($urandom_range(0, 3));
            w8    = 8'($urandom_range(0, 255));
            d     = $urandom;
            addr  = {22'd0, w8, 2'b00};
            misal = ($urandom_range(0, 4) == 0);
            if (misal) addr[1:0] = 2'($urandom_range(1, 3));
            access(port, addr, wr, d, rq, rerr, lat, ok);
            checks++; if (!ok || rerr !== misal) begin failures++; $display("[TB] FAIL random%0d_err: got ok=%0d err=%b required err=%b", k, ok, rerr, misal); end
            if (misal) begin
                checks++; if (lat != 3) begin failures++; $display("[TB] FAIL random%0d_err_latency: got %0d required 3", k, lat); end
            end else if (wr == WR_NONE) begin
                checks++; if (rq !== refMem[w8] || lat != 4) begin failures++; $display("[TB] FAIL random%0d_read: got %h lat %0d required %h lat 4", k, rq, lat, refMem[w8]); end
            end else begin
                refMem[w8] = refApply(refMem[w8], wr, d);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rq; logic rerr, ok; int lat, n;
        preload(32'h3C0, $urandom);
        @(negedge clk);
        p1Req = 1'b1; p1Addr = 32'h200; p1Wr = WR_WORD; p1Data = $urandom;
        n = 0;
        while (memWr == WR_NONE && n < 20) begin @(negedge clk); n++; end
        checks++; if (memWr == WR_NONE) begin failures++; $display("[TB] FAIL midwrite_busy_timeout: got mem_write %0d required nonzero", memWr); end
        reset = 1'b1;
        p1Req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (memWr !== WR_NONE || memAddr !== 32'd0) begin failures++; $display("[TB] FAIL midwrite_idle: got write %0d addr %h required 0 0", memWr, memAddr); end
        checks++; if (p1Ack !== 1'b0) begin failures++; $display("[TB] FAIL midwrite_no_ack: got %b required 0", p1Ack); end
        n = 0;
        while (!memDone && n < 20) begin @(negedge clk); n++; end
        checks++; if (!memDone) begin failures++; $display("[TB] FAIL midwrite_drain_timeout: got done %b required 1", memDone); end
        access(0, 32'h3C0, WR_NONE, 32'd0, rq, rerr, lat, ok);
        checks++; if (!ok || lat != 5) begin failures++; $display("[TB] FAIL midwrite_gate_latency: got %0d (ok=%0d) required 5", lat, ok); end
        checks++; if (rq !== refMem[8'hF0] || rerr !== 1'b0) begin failures++; $display("[TB] FAIL midwrite_read: got %h err %b required %h err 0", rq, rerr, refMem[8'hF0]); end
    endtask

    task automatic test_protocol();
        checks++; if (dropSeen !== 1'b0) begin failures++; $display("[TB] FAIL req_drop: got %b required 0", dropSeen); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        for (int i = 0; i < 256; i++) refMem[i] = 32'd0;
        test_reset();
        test_single_read();
        test_write_read();
        test_byte_write();
        test_misaligned();
        test_contention();
        test_random();
        test_reset_mid_write();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
